// File: rtl/if_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : if_fetch                                                         |
// | Brief   : Instruction-fetch bus master feeding the IF pipeline register.   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module if_fetch #(
  parameter int               ADDR_W   = 30,
  parameter int               DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INSN = 32'h0000_0000,
  parameter int               TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              stall,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack,
  input  logic              bus_err,
  input  logic [DATA_W-1:0] bus_rd_data,
  output logic [DATA_W-1:0] insn,
  output logic              insn_fault,
  output logic              busy
);

  localparam int c_CNT_W = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = (TIMEOUT > 0) ? c_CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_READY  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_CNT_W-1:0]  r_wait_cnt;
  logic [DATA_W-1:0]   r_insn;
  logic                r_fault;
  logic                w_timeout;
  logic                w_term;

  assign bus_addr = if_pc;

  generate
    if (TIMEOUT != 0) begin : g_timeout
      assign w_timeout = (r_wait_cnt == c_CNT_MAX);
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    bus_req     = 1'b0;
    busy        = 1'b1;
    insn        = r_insn;
    insn_fault  = r_fault;
    w_term      = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        bus_req = 1'b1;
        w_term  = bus_ack | bus_err | w_timeout;
        busy    = ~w_term;
        if (bus_ack) begin
          insn        = bus_rd_data;
          insn_fault  = 1'b0;
          w_state_nxt = stall ? S_READY : S_ACCESS;
        end else if (bus_err || w_timeout) begin
          // Faulted accesses always pass through READY so bus_req drops.
          insn        = NOP_INSN;
          insn_fault  = 1'b1;
          w_state_nxt = S_READY;
        end
      end
      S_READY: begin
        busy = 1'b0;
        if (!stall) w_state_nxt = S_ACCESS;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_insn     <= NOP_INSN;
      r_fault    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_term) begin
        r_insn     <= insn;
        r_fault    <= insn_fault;
        r_wait_cnt <= '0;
      end else if (r_state == S_ACCESS && r_wait_cnt != c_CNT_MAX) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
